// File: rtl/alu_issue_if.sv
// alu_issue_if: request, ALU, response and debug signals of the ALU sequencer
interface alu_issue_if #(parameter int WIDTH = 4, parameter int NREGS = 4);
  localparam int AW = $clog2(NREGS);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [AW-1:0]    req_rd;
  logic [AW-1:0]    req_rs1;
  logic [AW-1:0]    req_rs2;
  logic             req_imm_en;
  logic [WIDTH-1:0] req_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_s;
  logic [WIDTH-1:0] alu_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [AW-1:0]    rsp_rd;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm,
    output alu_y, rsp_ready, dbg_addr,
    input  req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_rd, dbg_data
  );
  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm,
    input  alu_y, rsp_ready, dbg_addr,
    output req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_rd, dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: sequences register-file ALU instructions through an external combinational ALU
module alu_issue #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [2:0]       op_s_q, op_s_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             accept, exec;
  // r0 is never written, so reading regs_q[0] always yields zero
  always_comb begin
    accept   = state_q == IDLE && bus.req_valid;
    exec     = state_q == EXEC;
    state_d  = state_q == IDLE ? (bus.req_valid ? EXEC : IDLE) :
               exec ? RESP :
               (bus.rsp_ready || state_q != RESP) ? IDLE : RESP;
    op_a_d   = accept ? regs_q[bus.req_rs1] : op_a_q;
    op_b_d   = accept ? (bus.req_imm_en ? bus.req_imm : regs_q[bus.req_rs2]) : op_b_q;
    op_s_d   = accept ? bus.req_op : op_s_q;
    rd_d     = accept ? bus.req_rd : rd_q;
    result_d = exec ? bus.alu_y : result_q;
    regs_d   = regs_q;
    if (exec && rd_q != '0) regs_d[rd_q] = bus.alu_y;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      regs_q   <= '{default: '0};
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_s_q   <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_s_q   <= op_s_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.alu_a     = op_a_q;
  assign bus.alu_b     = op_b_q;
  assign bus.alu_s     = op_s_q;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data  = result_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.dbg_data  = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors, backpressure/reset sequences and random instructions vs. a reference model
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mreg [4];

  alu_issue_if #(.WIDTH(4), .NREGS(4)) bus ();
  alu_issue #(.WIDTH(4), .NREGS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // the combinational ALU the sequencer drives
  function automatic logic [3:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = ~a;
      3'd3: alu_f = a & b;
      3'd4: alu_f = a | b;
      3'd5: alu_f = a ^ b;
      3'd6: alu_f = ($signed(a) > $signed(b)) ? 4'd1 : 4'd0;
      default: alu_f = (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction
  always_comb bus.alu_y = alu_f(bus.alu_s, bus.alu_a, bus.alu_b);

  // reference: integer arithmetic on signed values, reduced modulo 16
  function automatic int ref_op(input int s, input int a, input int b);
    int sa, sb, r;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    r = 0;
    if (s == 0) r = sa + sb;
    if (s == 1) r = sa - sb;
    if (s == 2) r = -sa - 1;
    if (s == 3) r = a & b;
    if (s == 4) r = a | b;
    if (s == 5) r = a ^ b;
    if (s == 6) r = sa > sb ? 1 : 0;
    if (s == 7) r = a == b ? 1 : 0;
    return r & 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int ie, input int imm);
    bus.req_op = op[2:0];
    bus.req_rd = rd[1:0];
    bus.req_rs1 = rs1[1:0];
    bus.req_rs2 = rs2[1:0];
    bus.req_imm_en = ie[0];
    bus.req_imm = imm[3:0];
    bus.req_valid = 1'b1;
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int ie,
                       input int imm, input int stall, output int got);
    int a, b, e, cnt;
    @(negedge clk);
    drive(op, rd, rs1, rs2, ie, imm);
    cnt = 0;
    while (!bus.req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt == 20) check("req_ready_wait", 0, 1);
    a = rs1 == 0 ? 0 : mreg[rs1];
    b = ie != 0 ? imm : (rs2 == 0 ? 0 : mreg[rs2]);
    e = ref_op(op, a, b);
    if (rd != 0) mreg[rd] = e;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("exec_req_ready", bus.req_ready, 0);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    check("exec_alu_a", bus.alu_a, a);
    check("exec_alu_b", bus.alu_b, b);
    check("exec_alu_s", bus.alu_s, op);
    bus.rsp_ready = stall == 0;
    bus.dbg_addr = rd[1:0];
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_data", bus.rsp_data, e);
    check("rsp_rd", bus.rsp_rd, rd);
    check("wb_dbg", bus.dbg_data, rd == 0 ? 0 : e);
    got = int'(bus.rsp_data);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_data", bus.rsp_data, e);
      check("hold_rd", bus.rsp_rd, rd);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
  endtask

  typedef struct {int op; int rd; int rs1; int rs2; int ie; int imm; int exp;} vec_t;
  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    tbl[0] = '{0, 1, 0, 0, 1, 5, 5};
    tbl[1] = '{0, 2, 1, 0, 1, 4, 9};
    tbl[2] = '{1, 3, 1, 2, 0, 0, 12};
    tbl[3] = '{6, 3, 1, 2, 0, 0, 1};
    tbl[4] = '{6, 3, 2, 1, 0, 0, 0};
    tbl[5] = '{7, 3, 1, 1, 0, 0, 1};
    tbl[6] = '{2, 3, 1, 0, 0, 0, 10};
    tbl[7] = '{5, 3, 1, 0, 1, 3, 6};
    tbl[8] = '{4, 0, 1, 0, 1, 2, 7};
    bus.req_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.dbg_addr = 2'd0;
    foreach (mreg[i]) mreg[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_s", bus.alu_s, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_rd", bus.rsp_rd, 0);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1 check($sformatf("rst_dbg%0d", i), bus.dbg_data, 0);
    end

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ie, tbl[i].imm, 0, got);
      check($sformatf("vec%0d", i), got, tbl[i].exp);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1 check($sformatf("tbl_dbg%0d", i), bus.dbg_data, i == 0 ? 0 : i == 1 ? 5 : i == 2 ? 9 : 6);
    end

    // backpressure: and r3=r1,r2 held in RESP while another request waits
    @(negedge clk);
    drive(3, 3, 1, 2, 0, 0);
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", bus.rsp_valid, 1);
    check("bp_data", bus.rsp_data, 1);
    check("bp_rd", bus.rsp_rd, 3);
    drive(0, 2, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_data", bus.rsp_data, 1);
      check("bp_hold_rd", bus.rsp_rd, 3);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", bus.req_ready, 1);
    check("bp_idle_valid", bus.rsp_valid, 0);
    check("bp_not_taken_s", bus.alu_s, 3);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_new_alu_a", bus.alu_a, 0);
    check("bp_new_alu_b", bus.alu_b, 1);
    check("bp_new_alu_s", bus.alu_s, 0);
    @(negedge clk);
    check("bp_new_data", bus.rsp_data, 1);
    check("bp_new_rd", bus.rsp_rd, 2);
    mreg[3] = 1;
    mreg[2] = 1;

    // reset during EXEC of add r1=r1+1
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.dbg_addr = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rexec_valid", bus.rsp_valid, 0);
      check("rexec_ready", bus.req_ready, 1);
      check("rexec_r1", bus.dbg_data, 0);
    end
    foreach (mreg[i]) mreg[i] = 0;
    issue(0, 1, 0, 0, 1, 3, 0, got);
    check("post_reset", got, 3);

    for (int n = 0; n < 40; n++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 2), got);
      bus.dbg_addr = 2'($urandom_range(0, 3));
      #1 check("rand_dbg", bus.dbg_data, mreg[bus.dbg_addr]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
